// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit lab core: fetch FSM states, datapath widths
// and the two canonical program entry points.
package core_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  localparam logic [PC_W-1:0] PROG0_START = 8'h00;
  localparam logic [PC_W-1:0] PROG1_START = 8'h40;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

  // Retired count sticks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch / PC unit: reads one instruction at a time, hands it to
// decode over valid/ready and follows ALU redirects until HALT is accepted.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// FETCH | imem read strobe asserted at pc
// WAIT  | read data arrives; captured into the issue register
// ISSUE | instruction presented to decode until accepted
// DONE  | HALT accepted; waiting for a new start_i
module fetch_unit
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [PC_W-1:0]    start_addr_i,
  output logic               imem_rd_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   retired_o
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_instr_pc;
  logic               r_valid;
  logic               r_done;
  logic [CNT_W-1:0]   r_retired;

  logic w_start;
  logic w_accept;
  logic w_halt;

  // start_i only matters when no program is in flight.
  assign w_start  = start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept = (r_state == ISSUE) && instr_ready_i;
  assign w_halt   = (r_instr == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_pc      <= start_addr_i;
            r_retired <= '0;
            r_done    <= 1'b0;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_instr    <= imem_data_i;
          r_instr_pc <= r_pc;
          r_valid    <= 1'b1;
          r_state    <= ISSUE;
        end
        ISSUE: begin
          if (w_accept) begin
            r_retired <= sat_inc(r_retired);
            r_valid   <= 1'b0;
            // HALT wins over any branch decision on the same handshake.
            if (w_halt) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (branch_taken_i) begin
              r_pc    <= branch_target_i;
              r_state <= FETCH;
            end else begin
              r_pc    <= r_pc + PC_W'(1);
              r_state <= FETCH;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign imem_rd_o     = (r_state == FETCH);
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign instr_valid_o = r_valid;
  assign busy_o        = (r_state == FETCH) || (r_state == WAIT) || (r_state == ISSUE);
  assign done_o        = r_done;
  assign retired_o     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a table of single-
// instruction redirect vectors, and random programs against a transaction model.
module tb_fetch_unit;
  import core_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_i;
  logic [PC_W-1:0]    start_addr_i;
  logic               imem_rd_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic               branch_taken_i;
  logic [PC_W-1:0]    branch_target_i;
  logic               busy_o;
  logic               done_o;
  logic [CNT_W-1:0]   retired_o;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .start_addr_i   (start_addr_i),
    .imem_rd_o      (imem_rd_o),
    .imem_addr_o    (imem_addr_o),
    .imem_data_i    (imem_data_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .retired_o      (retired_o)
  );

  // Synchronous instruction memory: data valid one cycle after the strobe,
  // junk otherwise so a mistimed capture is visible.
  logic [INSTR_W-1:0] imem [0:255];
  always @(posedge clk) begin
    if (imem_rd_o) imem_data_i <= imem[imem_addr_o];
    else           imem_data_i <= 9'h0AA;
  end

  int vec_n = 0;
  int err_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start_i = 1'b0; instr_ready_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = '0; start_addr_i = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [PC_W-1:0] addr);
    start_i = 1'b1; start_addr_i = addr;
    tick();
    start_i = 1'b0;
  endtask

  typedef struct {
    logic [PC_W-1:0]    start;
    logic [INSTR_W-1:0] instr;
    logic               br;
    logic [PC_W-1:0]    tgt;
    logic               exp_done;
    logic [PC_W-1:0]    exp_next;
  } vec_t;

  vec_t vtab [5];

  logic [PC_W-1:0]    m_pc;
  int                 m_ret;
  bit                 m_done;
  logic [INSTR_W-1:0] held;

  initial begin
    vtab[0] = '{8'h40, 9'h012, 1'b1, 8'h4A, 1'b0, 8'h4A};
    vtab[1] = '{8'hFF, 9'h013, 1'b0, 8'h00, 1'b0, 8'h00};
    vtab[2] = '{8'h10, 9'h1FF, 1'b1, 8'h10, 1'b1, 8'h00};
    vtab[3] = '{8'h7F, 9'h0FF, 1'b0, 8'h33, 1'b0, 8'h80};
    vtab[4] = '{8'h05, 9'h1FE, 1'b1, 8'hFF, 1'b0, 8'hFF};
    for (int i = 0; i < 256; i++) imem[i] = 9'(i + 1);

    // Reset state
    do_reset();
    check("rst_rd", 32'(imem_rd_o), 0);
    check("rst_addr", 32'(imem_addr_o), 0);
    check("rst_instr", 32'(instr_o), 0);
    check("rst_ipc", 32'(instr_pc_o), 0);
    check("rst_valid", 32'(instr_valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_retired", 32'(retired_o), 0);

    // Sequential run, ready tied high: one instruction every 3 cycles
    imem[0] = 9'h001; imem[1] = 9'h002; imem[2] = 9'h003; imem[3] = HALT_INSTR;
    instr_ready_i = 1'b1;
    pulse_start(PROG0_START);
    for (int k = 0; k < 4; k++) begin
      check("seq_rd", 32'(imem_rd_o), 1);
      check("seq_addr", 32'(imem_addr_o), 32'(k));
      check("seq_busy", 32'(busy_o), 1);
      tick(); tick();
      check("seq_valid", 32'(instr_valid_o), 1);
      check("seq_ipc", 32'(instr_pc_o), 32'(k));
      check("seq_instr", 32'(instr_o), 32'(imem[k]));
      tick();
    end
    check("seq_done", 32'(done_o), 1);
    check("seq_busy_end", 32'(busy_o), 0);
    check("seq_retired", 32'(retired_o), 4);
    check("seq_rd_end", 32'(imem_rd_o), 0);
    check("seq_valid_end", 32'(instr_valid_o), 0);

    // Backpressure in ISSUE, with a stray start_i that must be ignored
    imem[8'h20] = 9'h055; imem[8'h21] = HALT_INSTR;
    do_reset();
    pulse_start(8'h20);
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      start_i = (c == 0); start_addr_i = 8'h70;
      check("bp_valid", 32'(instr_valid_o), 1);
      check("bp_instr", 32'(instr_o), 32'h055);
      check("bp_ipc", 32'(instr_pc_o), 32'h20);
      check("bp_rd", 32'(imem_rd_o), 0);
      check("bp_retired", 32'(retired_o), 0);
      tick();
    end
    start_i = 1'b0;
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("bp_adv_rd", 32'(imem_rd_o), 1);
    check("bp_adv_addr", 32'(imem_addr_o), 32'h21);
    check("bp_adv_retired", 32'(retired_o), 1);
    check("bp_adv_valid", 32'(instr_valid_o), 0);

    // Reset in WAIT, coincident with start_i: reset wins
    imem[0] = 9'h001;
    do_reset();
    pulse_start(PROG0_START);
    tick();
    reset = 1'b1; start_i = 1'b1; start_addr_i = PROG1_START;
    tick();
    reset = 1'b0; start_i = 1'b0;
    check("mid_rst_rd", 32'(imem_rd_o), 0);
    check("mid_rst_addr", 32'(imem_addr_o), 0);
    check("mid_rst_valid", 32'(instr_valid_o), 0);
    check("mid_rst_instr", 32'(instr_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    tick();
    check("mid_rst_idle", 32'(busy_o), 0);
    pulse_start(PROG1_START);
    check("restart_rd", 32'(imem_rd_o), 1);
    check("restart_addr", 32'(imem_addr_o), 32'h40);
    check("restart_retired", 32'(retired_o), 0);

    // Table: one instruction, one handshake, check the redirect
    for (int v = 0; v < 5; v++) begin
      do_reset();
      imem[vtab[v].start] = vtab[v].instr;
      pulse_start(vtab[v].start);
      tick(); tick();
      check("tab_valid", 32'(instr_valid_o), 1);
      check("tab_ipc", 32'(instr_pc_o), 32'(vtab[v].start));
      check("tab_instr", 32'(instr_o), 32'(vtab[v].instr));
      instr_ready_i = 1'b1; branch_taken_i = vtab[v].br; branch_target_i = vtab[v].tgt;
      tick();
      instr_ready_i = 1'b0; branch_taken_i = 1'b0;
      check("tab_done", 32'(done_o), 32'(vtab[v].exp_done));
      check("tab_retired", 32'(retired_o), 1);
      if (vtab[v].exp_done) begin
        for (int c = 0; c < 3; c++) begin
          check("tab_halt_no_rd", 32'(imem_rd_o), 0);
          check("tab_halt_busy", 32'(busy_o), 0);
          tick();
        end
      end else begin
        check("tab_next_rd", 32'(imem_rd_o), 1);
        check("tab_next_addr", 32'(imem_addr_o), 32'(vtab[v].exp_next));
      end
    end

    // Random programs against a transaction-level model
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++)
        imem[i] = ($urandom_range(0, 11) == 0) ? HALT_INSTR : 9'($urandom_range(0, 510));
      do_reset();
      m_pc = 8'($urandom); m_ret = 0; m_done = 0;
      pulse_start(m_pc);
      for (int c = 0; c < 4000 && !m_done; c++) begin
        instr_ready_i   = ($urandom_range(0, 2) != 0);
        branch_taken_i  = $urandom_range(0, 1) == 1;
        branch_target_i = 8'($urandom);
        if (imem_rd_o) begin
          check("rnd_fetch_addr", 32'(imem_addr_o), 32'(m_pc));
          check("rnd_rd_busy", 32'(busy_o), 1);
        end
        if (instr_valid_o && instr_ready_i) begin
          check("rnd_ipc", 32'(instr_pc_o), 32'(m_pc));
          check("rnd_instr", 32'(instr_o), 32'(imem[m_pc]));
          check("rnd_retired", 32'(retired_o), 32'(m_ret));
          held = imem[m_pc];
          m_ret++;
          if (held == HALT_INSTR) m_done = 1;
          else if (branch_taken_i) m_pc = branch_target_i;
          else m_pc = m_pc + 8'd1;
        end
        tick();
      end
      instr_ready_i = 1'b0; branch_taken_i = 1'b0;
      check("rnd_finished", 32'(m_done), 1);
      check("rnd_done", 32'(done_o), 1);
      check("rnd_busy", 32'(busy_o), 0);
      check("rnd_final_retired", 32'(retired_o), 32'(m_ret));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
